// File: rtl/vga_timing.sv
// Raster timing generator: scan position, sync pulses, frame strobe and frame counter.
// Every output is registered from the next-position decode, so all outputs describe the same pixel.
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        ce,
  output logic [11:0] hpos,
  output logic [11:0] vpos,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        fsync,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing: every region must be non-zero and each total must not exceed 4096");
  end

  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_END   = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_FP_END   = 12'(V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_e;

  region_e     h_region_q, h_region_d;
  region_e     v_region_q, v_region_d;
  logic [11:0] hpos_q, hpos_d;
  logic [11:0] vpos_q, vpos_d;
  logic        video_on_q, video_on_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        fsync_q, fsync_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        h_wrap;

  always_comb begin
    h_wrap = (hpos_q == H_LAST);
    hpos_d = h_wrap ? 12'd0 : hpos_q + 12'd1;
    if (h_wrap) begin
      vpos_d = (vpos_q == V_LAST) ? 12'd0 : vpos_q + 12'd1;
    end else begin
      vpos_d = vpos_q;
    end

    case (h_region_q)
      ACTIVE:  h_region_d = (hpos_q == H_ACT_END)  ? FRONT  : ACTIVE;
      FRONT:   h_region_d = (hpos_q == H_FP_END)   ? SYNC   : FRONT;
      SYNC:    h_region_d = (hpos_q == H_SYNC_END) ? BACK   : SYNC;
      BACK:    h_region_d = h_wrap                 ? ACTIVE : BACK;
      default: h_region_d = ACTIVE;
    endcase

    // The vertical region only moves on the edge that ends a line.
    if (h_wrap) begin
      case (v_region_q)
        ACTIVE:  v_region_d = (vpos_q == V_ACT_END)  ? FRONT  : ACTIVE;
        FRONT:   v_region_d = (vpos_q == V_FP_END)   ? SYNC   : FRONT;
        SYNC:    v_region_d = (vpos_q == V_SYNC_END) ? BACK   : SYNC;
        BACK:    v_region_d = (vpos_q == V_LAST)     ? ACTIVE : BACK;
        default: v_region_d = ACTIVE;
      endcase
    end else begin
      v_region_d = v_region_q;
    end

    video_on_d  = (h_region_d == ACTIVE) && (v_region_d == ACTIVE);
    hsync_d     = (h_region_d == SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d     = (v_region_d == SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
    fsync_d     = h_wrap && (vpos_q == V_ACT_END);
    frame_cnt_d = frame_cnt_q + {7'd0, fsync_d};
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      h_region_q  <= BACK;
      v_region_q  <= BACK;
      hpos_q      <= H_LAST;
      vpos_q      <= V_LAST;
      video_on_q  <= 1'b0;
      hsync_q     <= ~H_SYNC_POL;
      vsync_q     <= ~V_SYNC_POL;
      fsync_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else if (ce) begin
      h_region_q  <= h_region_d;
      v_region_q  <= v_region_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      video_on_q  <= video_on_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fsync_q     <= fsync_d;
      frame_cnt_q <= frame_cnt_d;
    end else begin
      h_region_q  <= h_region_q;
      v_region_q  <= v_region_q;
      hpos_q      <= hpos_q;
      vpos_q      <= vpos_q;
      video_on_q  <= video_on_q;
      hsync_q     <= hsync_q;
      vsync_q     <= vsync_q;
      fsync_q     <= fsync_q;
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign hpos      = hpos_q;
  assign vpos      = vpos_q;
  assign video_on  = video_on_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign fsync     = fsync_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench: a default-timing instance and a tiny-timing instance, compared against
// a position-index reference model, a hand-computed first-line table, and strobe spacing checks.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, ce_a, rst_b, ce_b;
  logic [11:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic        video_on_a, hsync_a, vsync_a, fsync_a;
  logic        video_on_b, hsync_b, vsync_b, fsync_b;
  logic [7:0]  frame_cnt_a, frame_cnt_b;

  vga_timing dut_a (
    .pixel_clk(clk), .rst(rst_a), .ce(ce_a),
    .hpos(hpos_a), .vpos(vpos_a), .video_on(video_on_a),
    .hsync(hsync_a), .vsync(vsync_a), .fsync(fsync_a), .frame_cnt(frame_cnt_a)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) dut_b (
    .pixel_clk(clk), .rst(rst_b), .ce(ce_b),
    .hpos(hpos_b), .vpos(vpos_b), .video_on(video_on_b),
    .hsync(hsync_b), .vsync(vsync_b), .fsync(fsync_b), .frame_cnt(frame_cnt_b)
  );

  typedef struct {
    int h;
    int v;
    bit vid;
    bit hs;
    bit vs;
    bit fs;
    int fc;
  } obs_t;

  typedef struct {
    int   steps;
    obs_t exp;
  } vec_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint ka       = 0;
  longint kb       = 0;

  // Reference: after k enabled edges from reset the raster index is (T-1+k) mod T.
  function automatic obs_t ref_model(input int ha, input int hf, input int hsw, input int hb,
                                     input int va, input int vf, input int vsw, input int vb,
                                     input bit hp, input bit vp, input longint k);
    obs_t   r;
    int     ht  = ha + hf + hsw + hb;
    int     vt  = va + vf + vsw + vb;
    longint len = longint'(ht) * longint'(vt);
    longint idx = (len - 1 + k) % len;
    longint k0  = longint'(va) * longint'(ht) + 1;
    r.h   = int'(idx % ht);
    r.v   = int'(idx / ht);
    r.vid = (r.h < ha) && (r.v < va);
    r.hs  = (r.h >= ha + hf && r.h < ha + hf + hsw) ? hp : !hp;
    r.vs  = (r.v >= va + vf && r.v < va + vf + vsw) ? vp : !vp;
    r.fs  = (k >= 1) && (r.h == 0) && (r.v == va);
    r.fc  = (k >= k0) ? int'(((k - k0) / len + 1) % 256) : 0;
    return r;
  endfunction

  function automatic obs_t exp_a();
    return ref_model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, ka);
  endfunction

  function automatic obs_t exp_b();
    return ref_model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0, kb);
  endfunction

  function automatic obs_t get_a();
    obs_t r;
    r.h = int'(hpos_a); r.v = int'(vpos_a); r.vid = video_on_a; r.hs = hsync_a;
    r.vs = vsync_a; r.fs = fsync_a; r.fc = int'(frame_cnt_a);
    return r;
  endfunction

  function automatic obs_t get_b();
    obs_t r;
    r.h = int'(hpos_b); r.v = int'(vpos_b); r.vid = video_on_b; r.hs = hsync_b;
    r.vs = vsync_b; r.fs = fsync_b; r.fc = int'(frame_cnt_b);
    return r;
  endfunction

  function automatic vec_t mk(input int steps, input int h, input int v, input bit vid,
                              input bit hs, input bit vs);
    vec_t t;
    t.steps = steps;
    t.exp.h = h; t.exp.v = v; t.exp.vid = vid; t.exp.hs = hs; t.exp.vs = vs;
    t.exp.fs = 1'b0; t.exp.fc = 0;
    return t;
  endfunction

  task automatic check_field(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
    check_field({tag, ".hpos"},      act.h,        exp.h);
    check_field({tag, ".vpos"},      act.v,        exp.v);
    check_field({tag, ".video_on"},  int'(act.vid), int'(exp.vid));
    check_field({tag, ".hsync"},     int'(act.hs),  int'(exp.hs));
    check_field({tag, ".vsync"},     int'(act.vs),  int'(exp.vs));
    check_field({tag, ".fsync"},     int'(act.fs),  int'(exp.fs));
    check_field({tag, ".frame_cnt"}, act.fc,       exp.fc);
  endtask

  // One clock; the model advances from the inputs that were stable at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_a && ce_a) ka++;
    if (rst_b && ce_b) kb++;
    #1;
  endtask

  initial begin
    vec_t tbl[9];
    int   hs_low;
    int   vid_hi;
    int   nfs;
    int   last;
    int   rises;
    int   highs;
    bit   prev_fs;

    rst_a = 1'b0; ce_a = 1'b1; rst_b = 1'b0; ce_b = 1'b0;

    tbl[0] = mk(0,   799, 524, 1'b0, 1'b1, 1'b1);
    tbl[1] = mk(1,   0,   0,   1'b1, 1'b1, 1'b1);
    tbl[2] = mk(639, 639, 0,   1'b1, 1'b1, 1'b1);
    tbl[3] = mk(1,   640, 0,   1'b0, 1'b1, 1'b1);
    tbl[4] = mk(16,  656, 0,   1'b0, 1'b0, 1'b1);
    tbl[5] = mk(95,  751, 0,   1'b0, 1'b0, 1'b1);
    tbl[6] = mk(1,   752, 0,   1'b0, 1'b1, 1'b1);
    tbl[7] = mk(47,  799, 0,   1'b0, 1'b1, 1'b1);
    tbl[8] = mk(1,   0,   1,   1'b1, 1'b1, 1'b1);

    // Reset held with ce=1, then the first line walked through the table.
    repeat (5) tick();
    check_obs("reset_a", get_a(), tbl[0].exp);
    rst_a  = 1'b1;
    hs_low = 0;
    vid_hi = 0;
    for (int i = 1; i < 9; i++) begin
      for (int s = 0; s < tbl[i].steps; s++) begin
        tick();
        if (!hsync_a) hs_low++;
        if (video_on_a) vid_hi++;
      end
      check_obs($sformatf("table%0d", i), get_a(), tbl[i].exp);
    end
    check_field("hsync_low_width", hs_low, 96);
    check_field("video_on_count", vid_hi, 641);

    // Random clock enable against the model, with an asynchronous reset in the middle.
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) begin
        #2 rst_a = 1'b0;
        #1 ka = 0;
        check_obs("async_reset_a", get_a(), exp_a());
        tick();
        rst_a = 1'b1;
      end
      ce_a = ($urandom_range(0, 1) == 1);
      tick();
      check_obs("rand_a", get_a(), exp_a());
    end
    ce_a = 1'b0;

    // Tiny timing: 300 frames at full rate, including the frame counter wrap.
    check_obs("reset_b", get_b(), exp_b());
    rst_b = 1'b1;
    ce_b  = 1'b1;
    nfs   = 0;
    last  = -1;
    for (int i = 0; i < 300 * 48; i++) begin
      tick();
      check_obs("small", get_b(), exp_b());
      if (fsync_b) begin
        nfs++;
        if (last >= 0) check_field("fsync_spacing", i - last, 48);
        last = i;
        if (nfs == 255) check_field("frame_cnt_255", int'(frame_cnt_b), 255);
        if (nfs == 256) check_field("frame_cnt_wrap", int'(frame_cnt_b), 0);
      end
    end
    check_field("fsync_count", nfs, 300);

    // Mid-frame asynchronous reset, then a 1-in-4 clock enable.
    for (int i = 0; i < 30; i++) tick();
    #2 rst_b = 1'b0;
    #1 kb = 0;
    check_obs("async_reset_b", get_b(), exp_b());
    tick();
    rst_b   = 1'b1;
    rises   = 0;
    highs   = 0;
    last    = -1;
    prev_fs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      ce_b = (i % 4 == 0);
      tick();
      check_obs("ce_quarter", get_b(), exp_b());
      if (fsync_b) highs++;
      if (fsync_b && !prev_fs) begin
        rises++;
        if (last >= 0) check_field("fsync_spacing_ce4", i - last, 192);
        last = i;
      end
      prev_fs = fsync_b;
    end
    check_field("fsync_rises_ce4", rises, 3);
    check_field("fsync_stretch_ce4", highs, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator that drives the scan-position interface consumed by the Pong object and renderer blocks: hpos, vpos, fsync, and video-active.
- Produces the monitor sync pulses hsync and vsync.
- Runs on the pixel clock, gated by a clock-enable so slower pixel rates can be derived from a faster clock.
- Sits between the clock/reset logic and every pixel-producing block.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync asserted level (0 = active-low)
V_SYNC_POL, 0, vsync asserted level (0 = active-low)

Ports:
pixel_clk  in  1  pixel clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ce  in  1  clock enable; state advances only on edges where ce=1
hpos  out  12  current horizontal position, 0..H_TOTAL-1
vpos  out  12  current vertical position, 0..V_TOTAL-1
video_on  out  1  1 when hpos<H_ACTIVE and vpos<V_ACTIVE
hsync  out  1  horizontal sync at H_SYNC_POL level during sync region
vsync  out  1  vertical sync at V_SYNC_POL level during sync region
fsync  out  1  one-ce-cycle frame strobe at start of vertical blanking
frame_cnt  out  8  frames completed, wraps 255->0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525 default).
- Elaboration error if either total exceeds 4096, or any region is 0.
- Reset (rst=0, asynchronous, immediate):
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1
  - video_on=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
  - fsync=0, frame_cnt=0
  - Reset position is the last back-porch pixel, so all outputs are mutually consistent.
- Reset release is registered; the first ce=1 edge after release moves to (0,0) with video_on=1.
- ce=0: every output, including fsync, holds its value. fsync therefore stretches across ce-low cycles; consumers gate it with ce.
- Horizontal state machine, one state per region, position drives transitions:
  - ACTIVE (0..H_ACTIVE-1)
  - FRONT (..+H_FP-1)
  - SYNC (..+H_SYNC-1)
  - BACK (..H_TOTAL-1)
  - BACK -> ACTIVE when hpos wraps H_TOTAL-1 -> 0.
- Vertical state machine: same four regions over lines. vpos advances only on the ce edge where hpos wraps. vpos wraps V_TOTAL-1 -> 0.
- All outputs are registered and describe the same position; no output lags hpos/vpos.
- hsync is asserted exactly when hpos is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751] by default.
- vsync is asserted exactly when vpos is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491] by default. vsync changes only on line boundaries, together with hpos=0.
- fsync: 1 for exactly one ce cycle, on the cycle where (hpos,vpos)=(0,V_ACTIVE); 0 otherwise.
- frame_cnt increments on the same edge that fsync rises.
- Exactly one fsync per frame, including the first frame after reset.
- Reset asserted mid-frame: immediate return to reset values; no partial fsync or frame_cnt increment.
- No combinational path from ce to any output.

Test Plan:
- Reset: hold rst=0 for 5 clocks with ce=1 -> hpos=799, vpos=524, video_on=0, hsync=1, vsync=1, fsync=0, frame_cnt=0; first ce edge after release -> (0,0), video_on=1.
- Line timing, ce=1 constant: hsync=0 for exactly 96 clocks starting at hpos=656; video_on=1 for 640 clocks per active line; hpos 799 -> 0 coincides with vpos increment.
- Frame timing: run 2 full frames (840000 clocks) -> fsync pulses exactly twice, 420000 clocks apart, each at (0,480) and 1 clock wide; vsync=0 for exactly 1600 clocks, on lines 490-491; frame_cnt=2.
- Clock enable: drive ce with a 1-in-4 pattern -> all outputs hold on ce=0 clocks; fsync spacing becomes 1680000 clocks; position sequence matches the ce=1 run.
- Async reset mid-frame: assert rst=0 at (300,200) between clock edges -> outputs reach reset values within 1 ns, with no clock edge; frame_cnt=0; next frame's fsync still occurs exactly once.
- Wrap and small parameters: set H=4/1/2/1, V=3/1/1/1 and run 300 frames -> frame_cnt wraps 255 -> 0 at frame 256; hpos and vpos never exceed 7 and 5.
